fifo_stream_egress: RTL and testbench
=====================================

# fifo_stream_egress

Registered valid/ready egress stage placed directly downstream of the crossbar's synchronous FIFO. It drains the FIFO's push/pop-style output (`data_o`/`empty_o`/`pop_i`) into a standard valid/ready stream toward a slave or master port. A two-entry output buffer (main plus skid) sustains one beat per cycle. `fifo_pop_o` depends only on local state and `fifo_empty_i`, never on `ready_i`, so no combinational path runs from the consumer back into the FIFO.

## Interface
Parameters:
- `dtype`, default `logic [31:0]`: payload type; must match the FIFO's `dtype`.
- `CNT_WIDTH`, default 16: width of the transferred-beat counter.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous clear; asserted in the same cycle as the FIFO's `flush_i`.
- `fifo_data_i`  in  dtype  FIFO head entry (FIFO `data_o`).
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_pop_o`  out  1  drives FIFO `pop_i`.
- `valid_o`  out  1  output stream valid.
- `ready_i`  in  1  output stream ready.
- `data_o`  out  dtype  output stream payload.
- `occupancy_o`  out  2  entries held locally: 0, 1 or 2.
- `beats_o`  out  CNT_WIDTH  count of completed output handshakes; wraps modulo 2^CNT_WIDTH.

## Operation
- Storage:
  - Main register A drives `data_o`.
  - Skid register B holds the next beat.
  - `valid_o = (state != EMPTY)`.
- States:
  - EMPTY: no entries.
  - ONE: A valid.
  - TWO: A and B valid.
- Signals:
  - `xfer = valid_o & ready_i`.
  - `pop = fifo_pop_o = !flush_i & !fifo_empty_i & (state != TWO)`.
- Popped data is sampled from `fifo_data_i` in the same cycle `pop` is high. The FIFO head is combinational from its memory, so this data is valid.
- Transitions when `flush_i` = 0:
  - EMPTY, pop → ONE, A ← fifo_data_i.
  - EMPTY, no pop → EMPTY.
  - ONE, xfer & pop → ONE, A ← fifo_data_i.
  - ONE, xfer & !pop → EMPTY.
  - ONE, !xfer & pop → TWO, B ← fifo_data_i.
  - ONE, !xfer & !pop → ONE, A held.
  - TWO, xfer → ONE, A ← B (pop is 0 in TWO).
  - TWO, !xfer → TWO, A and B held.
- Payload stability: while `valid_o` = 1 and `ready_i` = 0, `data_o` must not change. This is AXI-style stability; valid is never retracted except by flush or reset.
- Beat counter:
  - `beats_o` increments by 1 on every `xfer`.
  - Flush does not clear it; only reset does.
  - Overflow wraps from 2^CNT_WIDTH−1 to 0.
- Flush:
  - Next state EMPTY; A/B contents are don't-care.
  - `fifo_pop_o` is forced to 0 in the flush cycle.
  - A handshake completing in the flush cycle still increments `beats_o`.
- `occupancy_o` = 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Reset values:
  - state EMPTY, `valid_o` = 0, `data_o` = '0, A = B = '0.
  - `occupancy_o` = 0, `beats_o` = 0.
  - `fifo_pop_o` is combinational and equals `!fifo_empty_i & !flush_i` during reset.
- Latency: an entry popped in cycle N is on `data_o` with `valid_o` = 1 from cycle N+1. A FIFO push in cycle N−1 gives earliest `valid_o` at N+1.
- Throughput: one beat per cycle sustained while `ready_i` = 1 and the FIFO is non-empty. State stays ONE.
- Stall response:
  - A `ready_i` low for one cycle moves state to TWO.
  - Popping stops in TWO; no beat is lost or duplicated.
- Reset mid-operation: held beats are dropped and `valid_o` falls asynchronously. The FIFO is reset by the same `rst_ni`.
- No combinational path from `ready_i` to `fifo_pop_o` or to `fifo_data_i` usage.

## Test plan
- **Reset/idle:** assert `rst_ni` = 0 with `fifo_empty_i` = 1 → `valid_o` = 0, `data_o` = 0, `occupancy_o` = 0, `beats_o` = 0, `fifo_pop_o` = 0.
- **Streaming:** push 0x11, 0x22, 0x33, 0x44 into the FIFO on consecutive cycles with `ready_i` = 1 → `data_o` shows 0x11..0x44 on 4 consecutive cycles starting 2 cycles after the first push. `beats_o` = 4 and `occupancy_o` returns to 0.
- **Backpressure:** FIFO holds 0xA0..0xA3 and `ready_i` = 0 for 5 cycles → `occupancy_o` = 2, `fifo_pop_o` = 0, `data_o` = 0xA0 stable. Then `ready_i` = 1 → 0xA0..0xA3 delivered in order, one per cycle, with no gaps.
- **Single-cycle stall:** a `ready_i` pattern of 1,0,1,1 during streaming → order preserved, no duplicate beat, state passes through TWO once.
- **Flush:** in state TWO holding 0x55 and 0x66, assert `flush_i` for 1 cycle with `ready_i` = 0 → the next cycle has `valid_o` = 0 and `occupancy_o` = 0, and `fifo_pop_o` = 0 during the flush cycle. `beats_o` is unchanged.
- **Counter wrap:** `CNT_WIDTH` = 4, stream 17 beats → `beats_o` reads 15 and then 0 after the 16th beat, then 1 after the 17th.

Source files
------------

// File: rtl/fifo_stream_egress.sv
// Drains a synchronous FIFO head into a valid/ready stream through a main+skid buffer.
// Popped beat is on data_o the next cycle; pop never depends on ready_i, so a stall parks one beat in the skid.
module fifo_stream_egress #(
   parameter type dtype     = logic [31:0],
   parameter int  CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  dtype                 fifo_data_i,
   input  logic                 fifo_empty_i,
   output logic                 fifo_pop_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output dtype                 data_o,
   output logic [1:0]           occupancy_o,
   output logic [CNT_WIDTH-1:0] beats_o
);

   // Encoding doubles as the local occupancy count.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   dtype                 r_a;
   dtype                 r_b;
   dtype                 w_a_nxt;
   dtype                 w_b_nxt;
   logic [CNT_WIDTH-1:0] r_beats;
   logic                 w_pop;
   logic                 w_xfer;

   assign w_pop       = !flush_i && !fifo_empty_i && (r_state != S_TWO);
   assign w_xfer      = valid_o && ready_i;
   assign fifo_pop_o  = w_pop;
   assign valid_o     = (r_state != S_EMPTY);
   assign data_o      = r_a;
   assign occupancy_o = r_state;
   assign beats_o     = r_beats;

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      if (flush_i) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_pop) begin
                  w_state_nxt = S_ONE;
                  w_a_nxt     = fifo_data_i;
               end
            end
            S_ONE: begin
               if (w_xfer && w_pop) begin
                  w_a_nxt = fifo_data_i;
               end else if (w_xfer) begin
                  w_state_nxt = S_EMPTY;
               end else if (w_pop) begin
                  w_state_nxt = S_TWO;
                  w_b_nxt     = fifo_data_i;
               end
            end
            S_TWO: begin
               // Skid beat moves up; no pop can happen in this state.
               if (w_xfer) begin
                  w_state_nxt = S_ONE;
                  w_a_nxt     = r_b;
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_EMPTY;
         r_a     <= '0;
         r_b     <= '0;
         r_beats <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         // A handshake in a flush cycle still counts.
         if (w_xfer) begin
            r_beats <= r_beats + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_egress.sv
// Bench for fifo_stream_egress: FIFO modelled as a queue, egress buffer modelled as a
// bounded queue of held beats; directed scenarios plus a randomized run.
module tb_fifo_stream_egress;

   logic        clk;
   logic        rst_ni;
   logic        flush_i;
   logic [31:0] fifo_data_i;
   logic        fifo_empty_i;
   logic        fifo_pop_o;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic [1:0]  occupancy_o;
   logic [3:0]  beats_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] fifo_q[$];
   logic [31:0] lq[$];
   int          m_beats = 0;

   fifo_stream_egress #(
      .dtype    (logic [31:0]),
      .CNT_WIDTH(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .fifo_data_i (fifo_data_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_pop_o  (fifo_pop_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .occupancy_o (occupancy_o),
      .beats_o     (beats_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_fifo();
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_data_i  = (fifo_q.size() == 0) ? $urandom : fifo_q[0];
   endtask

   // One clock edge: the model consumes the inputs the DUT sees at that edge.
   task automatic advance();
      bit          xfer;
      bit          pop;
      logic [31:0] head;
      xfer = (lq.size() != 0) && ready_i;
      pop  = !flush_i && (fifo_q.size() != 0) && (lq.size() < 2);
      head = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
      @(posedge clk);
      if (xfer) m_beats = (m_beats + 1) % 16;
      if (flush_i) begin
         lq.delete();
         fifo_q.delete();
      end else begin
         if (xfer) void'(lq.pop_front());
         if (pop) begin
            lq.push_back(head);
            void'(fifo_q.pop_front());
         end
      end
      #1;
      drive_fifo();
   endtask

   task automatic do_reset();
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      fifo_q.delete();
      lq.delete();
      m_beats = 0;
      drive_fifo();
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      fifo_q.delete();
      drive_fifo();
      #3;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
      checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
      checks++; if (beats_o !== 4'd0) begin errors++; $display("FAIL reset_beats: got %0d want 0", beats_o); end
      checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop_empty: got %b want 0", fifo_pop_o); end
      fifo_q.push_back(32'h1);
      drive_fifo();
      #1;
      checks++; if (fifo_pop_o !== 1'b1) begin errors++; $display("FAIL reset_pop_nonempty: got %b want 1", fifo_pop_o); end
      flush_i = 1'b1;
      #1;
      checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop_flush: got %b want 0", fifo_pop_o); end
      flush_i = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b want 0", valid_o); end
      do_reset();
   endtask

   task automatic test_streaming();
      logic [31:0] vals[4];
      int          b0;
      vals = '{32'h11, 32'h22, 32'h33, 32'h44};
      b0 = m_beats;
      fifo_q.push_back(vals[0]);
      drive_fifo();
      for (int c = 0; c < 8; c++) begin
         ready_i = 1'b1;
         flush_i = 1'b0;
         #1;
         checks++;
         if (valid_o !== ((c >= 1) && (c <= 4))) begin
            errors++; $display("FAIL stream_valid c=%0d: got %b", c, valid_o);
         end
         if ((c >= 1) && (c <= 4)) begin
            checks++;
            if (data_o !== vals[c-1]) begin
               errors++; $display("FAIL stream_data c=%0d: got %h want %h", c, data_o, vals[c-1]);
            end
         end
         advance();
         if (c < 3) begin
            fifo_q.push_back(vals[c+1]);
            drive_fifo();
         end
      end
      checks++; if (beats_o !== 4'((b0 + 4) % 16)) begin errors++; $display("FAIL stream_beats: got %0d want %0d", beats_o, (b0 + 4) % 16); end
      checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL stream_occ: got %0d want 0", occupancy_o); end
   endtask

   task automatic test_backpressure();
      logic [31:0] vals[4];
      vals = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      for (int i = 0; i < 4; i++) fifo_q.push_back(vals[i]);
      drive_fifo();
      for (int c = 0; c < 5; c++) begin
         ready_i = 1'b0;
         flush_i = 1'b0;
         #1;
         if (c >= 2) begin
            checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL bp_occ c=%0d: got %0d want 2", c, occupancy_o); end
            checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL bp_pop c=%0d: got %b want 0", c, fifo_pop_o); end
            checks++; if (data_o !== 32'hA0) begin errors++; $display("FAIL bp_data c=%0d: got %h want a0", c, data_o); end
         end
         advance();
      end
      for (int k = 0; k < 4; k++) begin
         ready_i = 1'b1;
         #1;
         checks++;
         if ((valid_o !== 1'b1) || (data_o !== vals[k])) begin
            errors++; $display("FAIL bp_drain k=%0d: got v=%b d=%h want v=1 d=%h", k, valid_o, data_o, vals[k]);
         end
         advance();
      end
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", valid_o); end
   endtask

   task automatic test_single_stall();
      logic [31:0] got[$];
      bit          pat[5];
      int          twos;
      pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      twos = 0;
      for (int i = 0; i < 6; i++) fifo_q.push_back(32'hC0 + i);
      drive_fifo();
      for (int c = 0; c < 20; c++) begin
         ready_i = (c < 5) ? pat[c] : 1'b1;
         flush_i = 1'b0;
         #1;
         if (occupancy_o == 2'd2) twos++;
         if (valid_o && ready_i) got.push_back(data_o);
         advance();
      end
      checks++; if (got.size() != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", got.size()); end
      for (int i = 0; i < 6; i++) begin
         if (i < got.size()) begin
            checks++;
            if (got[i] !== 32'hC0 + i) begin errors++; $display("FAIL stall_order i=%0d: got %h want %h", i, got[i], 32'hC0 + i); end
         end
      end
      checks++; if (twos != 1) begin errors++; $display("FAIL stall_two_cycles: got %0d want 1", twos); end
   endtask

   task automatic test_flush();
      int b0;
      fifo_q.push_back(32'h55);
      fifo_q.push_back(32'h66);
      fifo_q.push_back(32'h77);
      drive_fifo();
      ready_i = 1'b0;
      flush_i = 1'b0;
      advance();
      advance();
      #1;
      checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy_o); end
      b0 = m_beats;
      flush_i = 1'b1;
      #1;
      checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL flush_pop_two: got %b want 0", fifo_pop_o); end
      advance();
      flush_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_o); end
      checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy_o); end
      checks++; if (beats_o !== 4'(b0)) begin errors++; $display("FAIL flush_beats: got %0d want %0d", beats_o, b0); end
      fifo_q.push_back(32'h88);
      fifo_q.push_back(32'h99);
      drive_fifo();
      advance();
      b0 = m_beats;
      flush_i = 1'b1;
      ready_i = 1'b1;
      #1;
      checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL flush_pop_one: got %b want 0", fifo_pop_o); end
      checks++; if ((valid_o !== 1'b1) || (data_o !== 32'h88)) begin errors++; $display("FAIL flush_head: got v=%b d=%h want v=1 d=88", valid_o, data_o); end
      advance();
      flush_i = 1'b0;
      ready_i = 1'b0;
      #1;
      checks++; if (beats_o !== 4'((b0 + 1) % 16)) begin errors++; $display("FAIL flush_xfer_beats: got %0d want %0d", beats_o, (b0 + 1) % 16); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b want 0", valid_o); end
   endtask

   task automatic test_wrap();
      int  k;
      bit  xfer;
      do_reset();
      for (int i = 0; i < 17; i++) fifo_q.push_back(32'hE00 + i);
      drive_fifo();
      k = 0;
      for (int c = 0; c < 40 && k < 17; c++) begin
         ready_i = 1'b1;
         flush_i = 1'b0;
         #1;
         xfer = valid_o && ready_i;
         advance();
         if (xfer) begin
            k++;
            checks++;
            if (beats_o !== 4'(k % 16)) begin errors++; $display("FAIL wrap_beats k=%0d: got %0d want %0d", k, beats_o, k % 16); end
         end
      end
      checks++; if (k != 17) begin errors++; $display("FAIL wrap_timeout: got %0d beats want 17", k); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         ready_i = ($urandom_range(0, 9) < 7);
         flush_i = ($urandom_range(0, 39) == 0);
         #1;
         checks++; if (valid_o !== (lq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, valid_o, lq.size() != 0); end
         if (lq.size() != 0) begin
            checks++; if (data_o !== lq[0]) begin errors++; $display("FAIL rnd_data c=%0d: got %h want %h", c, data_o, lq[0]); end
         end
         checks++; if (occupancy_o !== 2'(lq.size())) begin errors++; $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, occupancy_o, lq.size()); end
         checks++; if (beats_o !== 4'(m_beats)) begin errors++; $display("FAIL rnd_beats c=%0d: got %0d want %0d", c, beats_o, m_beats); end
         checks++;
         if (fifo_pop_o !== (!flush_i && (fifo_q.size() != 0) && (lq.size() < 2))) begin
            errors++; $display("FAIL rnd_pop c=%0d: got %b", c, fifo_pop_o);
         end
         advance();
         if ((fifo_q.size() < 4) && ($urandom_range(0, 2) != 0)) begin
            fifo_q.push_back($urandom);
            drive_fifo();
         end
      end
   endtask

   task automatic test_reset_mid();
      fifo_q.push_back(32'h1234);
      fifo_q.push_back(32'h5678);
      drive_fifo();
      ready_i = 1'b0;
      flush_i = 1'b0;
      advance();
      advance();
      #1;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", valid_o); end
      #1;
      rst_ni = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
      checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL midrst_occ: got %0d want 0", occupancy_o); end
      checks++; if (beats_o !== 4'd0) begin errors++; $display("FAIL midrst_beats: got %0d want 0", beats_o); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_single_stall();
      test_flush();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
